colour_rom_arbiter: RTL and testbench
=====================================

# colour_rom_arbiter

Shares one single-port colour ROM (8 × 24-bit, registered read) between two light channels. Each channel requests a colour index with a req/gnt handshake. The arbiter grants at most one read per cycle using round-robin priority, tracks in-flight reads through a tag pipeline matched to the ROM latency, and returns each colour to the correct channel's light register. It sits between the lights-selector channel controllers and the shared colour memory.

## Interface
- ROM_LATENCY, 2, edges from the ROM address being sampled to `rom_data` valid; legal range 1..4
- IDX_W, 3, colour index width
- DATA_W, 24, colour width (RGB, 8 bits each)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  when high, no new grants; in-flight reads complete normally
- req0  in  1  channel 0 request; held high with `idx0` stable until `gnt0` is seen
- idx0  in  IDX_W  channel 0 colour index
- req1  in  1  channel 1 request; same rules as channel 0
- idx1  in  IDX_W  channel 1 colour index
- gnt0  out  1  combinational; high in the cycle channel 0's request is accepted
- gnt1  out  1  combinational; high in the cycle channel 1's request is accepted
- rom_en  out  1  gnt0 | gnt1
- rom_addr  out  IDX_W  index of the granted channel; 0 when no grant
- rom_data  in  DATA_W  ROM read data
- light0  out  DATA_W  registered colour for channel 0
- light1  out  DATA_W  registered colour for channel 1
- valid0  out  1  one-cycle pulse in the first cycle `light0` shows a new value
- valid1  out  1  one-cycle pulse in the first cycle `light1` shows a new value
- busy  out  1  registered; high while any read is in flight

## Operation
- Reset (async, immediate):
  - light0 = light1 = 24'h000000
  - valid0/1 = 0, busy = 0
  - tag pipeline cleared
  - last-grant pointer = channel 1, so channel 0 wins first
- Arbitration is evaluated every cycle that rst = 0 and hold = 0.
  - Only one requester high: that requester is granted.
  - Both high: the channel not granted last is granted.
  - Neither high: no grant; the pointer is unchanged.
  - The pointer updates at the clock edge ending a grant cycle.
- A requester drops `req` or changes `idx` only after sampling `gnt` high at an edge. Holding `req` high after a grant is a new request.
- A grant may be issued every cycle (back-to-back). Grants to the same channel may also be back-to-back.
- Tag pipeline: ROM_LATENCY+1 stages of {vld, chan}. Stage 0 is loaded from the grant at the edge ending the grant cycle.
- When the final stage has vld = 1, `rom_data` is captured into light[chan] at that edge, and valid[chan] pulses for the following cycle.
- `busy` is the OR of all tag vld bits.
- `hold` only suppresses grants. `rom_en` is 0 while hold is high, and in-flight tags drain.
- No index is special; the arbiter passes ROM contents through unmodified.

## Timing
- Grant in cycle k: ROM samples the address at edge k+1. `rom_data` is valid during cycle k+ROM_LATENCY. The light register captures it at edge k+ROM_LATENCY+1, so the new light and valid pulse appear in cycle k+ROM_LATENCY+1.
- Latency from grant to light update is ROM_LATENCY+1 cycles (3 at the default), regardless of arbitration contention.
- Results return in grant order. With back-to-back grants, the light registers update on consecutive cycles.
- Two grants to the same channel, one cycle apart: the second result overwrites the first one cycle later. valid pulses in both cycles.
- Reset asserted mid-operation: all in-flight reads are discarded. `rom_data` arriving after reset is released is ignored, and no valid pulse is produced.
- Requests asserted in the same cycle rst is released are arbitrated in that cycle.

## Test plan
Bench ROM model contents: mem = {0:000000, 1:0000FF, 2:00FF00, 3:00FFFF, 4:FF0000, 5:FF00FF, 6:FFFF00, 7:FFFFFF}, with ROM_LATENCY = 2.
- Reset check: rst pulse with requests idle -> light0 = light1 = 000000, busy = 0, no valid pulses for 10 cycles.
- Single read: req0 with idx0 = 1 in cycle k -> gnt0 in cycle k; light0 = 0000FF and valid0 pulse in cycle k+3; busy high for cycles k+1..k+3.
- Contention: req0/idx0 = 2 and req1/idx1 = 4 held continuously from reset release -> grants alternate 0,1,0,1; light0 = 00FF00 and light1 = FF0000 on alternating cycles; no cycle has both grants.
- Back-to-back same channel: req1 held 3 cycles with idx1 = 5, 6, 7 changed after each gnt -> light1 = FF00FF, FFFF00, FFFFFF on three consecutive cycles, valid1 high for all three.
- Hold: hold = 1 with req0 pending -> no gnt0 and rom_en = 0 for the whole hold period. An earlier in-flight read still updates light0. First gnt0 appears in the cycle after hold falls.
- Reset mid-flight: grant idx0 = 3, then assert rst the next cycle -> light0 = 000000, no valid0 pulse, busy = 0 after reset.

Source files
------------

// File: rtl/colour_rom_arbiter_if.sv
// colour_rom_arbiter_if
// Groups the channel handshakes, the shared ROM bus and the per-channel light
// outputs into one bundle.
//   master : channel controllers plus colour ROM (drive req/idx and rom_data)
//   slave  : the arbiter (drives gnt, rom_en/rom_addr, light/valid)
// Signals:
//   req0/idx0/gnt0, req1/idx1/gnt1 : per-channel request handshake
//   rom_en/rom_addr/rom_data       : shared single-port colour ROM
//   light0/light1, valid0/valid1   : returned colours and update pulses
interface colour_rom_arbiter_if #(
  parameter int IDX_W  = 3,
  parameter int DATA_W = 24
);
  logic              req0;
  logic [IDX_W-1:0]  idx0;
  logic              gnt0;
  logic              req1;
  logic [IDX_W-1:0]  idx1;
  logic              gnt1;
  logic              rom_en;
  logic [IDX_W-1:0]  rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] light0;
  logic [DATA_W-1:0] light1;
  logic              valid0;
  logic              valid1;

  modport master (
    output req0, idx0, req1, idx1, rom_data,
    input  gnt0, gnt1, rom_en, rom_addr, light0, light1, valid0, valid1
  );

  modport slave (
    input  req0, idx0, req1, idx1, rom_data,
    output gnt0, gnt1, rom_en, rom_addr, light0, light1, valid0, valid1
  );
endinterface

// File: rtl/colour_rom_arbiter.sv
// colour_rom_arbiter
// Shares one registered-read colour ROM between two light channels. At most
// one request is granted per cycle (round-robin on contention); a tag
// pipeline follows each read through the ROM so its data lands in the
// light register of the channel that asked for it.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   hold : suppresses new grants; reads already in flight still complete
//   bus  : channel handshakes, ROM bus, light/valid outputs (slave side)
//   busy : registered, high while any read is in flight
module colour_rom_arbiter #(
  parameter int ROM_LATENCY = 2,
  parameter int IDX_W       = 3,
  parameter int DATA_W      = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  colour_rom_arbiter_if.slave  bus,
  output logic                 busy
);

  // Channel that received the most recent grant (1 after reset, so channel 0
  // wins the first contended cycle).
  logic last_q, last_d;

  // One {vld, chan} entry per edge between grant and light capture.
  logic [ROM_LATENCY:0] tag_vld_q, tag_vld_d;
  logic [ROM_LATENCY:0] tag_chan_q, tag_chan_d;

  logic [DATA_W-1:0] light0_q, light0_d;
  logic [DATA_W-1:0] light1_q, light1_d;
  logic              valid0_q, valid0_d;
  logic              valid1_q, valid1_d;
  logic              busy_q, busy_d;

  logic              gnt0_s, gnt1_s;
  logic [IDX_W-1:0]  rom_addr_s;
  logic              capture_s;
  logic              capture_chan_s;

  // Round-robin grant selection and ROM address mux.
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    rom_addr_s = {IDX_W{1'b0}};
    if (!rst && !hold) begin
      case ({bus.req1, bus.req0})
        2'b01:   gnt0_s = 1'b1;
        2'b10:   gnt1_s = 1'b1;
        2'b11: begin
          if (last_q) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
    if (gnt0_s) begin
      rom_addr_s = bus.idx0;
    end else if (gnt1_s) begin
      rom_addr_s = bus.idx1;
    end else begin
      rom_addr_s = {IDX_W{1'b0}};
    end
  end

  // rom_data for a read is valid during the cycle its tag sits one stage
  // before the last, so the light is written at the edge that loads the
  // last stage; the valid pulse then tracks that last stage.
  assign capture_s      = tag_vld_q[ROM_LATENCY-1];
  assign capture_chan_s = tag_chan_q[ROM_LATENCY-1];

  // Next-state for pointer, tag pipeline, lights, valid pulses and busy.
  always_comb begin
    last_d     = last_q;
    tag_vld_d  = {tag_vld_q[ROM_LATENCY-1:0], (gnt0_s | gnt1_s)};
    tag_chan_d = {tag_chan_q[ROM_LATENCY-1:0], gnt1_s};
    light0_d   = light0_q;
    light1_d   = light1_q;
    valid0_d   = 1'b0;
    valid1_d   = 1'b0;
    if (gnt0_s) begin
      last_d = 1'b0;
    end else if (gnt1_s) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
    if (capture_s && !capture_chan_s) begin
      light0_d = bus.rom_data;
      valid0_d = 1'b1;
    end else if (capture_s && capture_chan_s) begin
      light1_d = bus.rom_data;
      valid1_d = 1'b1;
    end else begin
      valid0_d = 1'b0;
      valid1_d = 1'b0;
    end
    busy_d = |tag_vld_d;
  end

  // State registers; reset discards every in-flight read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= 1'b1;
      tag_vld_q  <= {(ROM_LATENCY+1){1'b0}};
      tag_chan_q <= {(ROM_LATENCY+1){1'b0}};
      light0_q   <= {DATA_W{1'b0}};
      light1_q   <= {DATA_W{1'b0}};
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      last_q     <= last_d;
      tag_vld_q  <= tag_vld_d;
      tag_chan_q <= tag_chan_d;
      light0_q   <= light0_d;
      light1_q   <= light1_d;
      valid0_q   <= valid0_d;
      valid1_q   <= valid1_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt0     = gnt0_s;
  assign bus.gnt1     = gnt1_s;
  assign bus.rom_en   = gnt0_s | gnt1_s;
  assign bus.rom_addr = rom_addr_s;
  assign bus.light0   = light0_q;
  assign bus.light1   = light1_q;
  assign bus.valid0   = valid0_q;
  assign bus.valid1   = valid1_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_colour_rom_arbiter.sv
// tb_colour_rom_arbiter
// Directed bench: a per-cycle vector table for single reads, contention and
// back-to-back grants, then hand-written sequences for hold and mid-flight
// reset. A two-edge ROM model supplies rom_data.
module tb_colour_rom_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic busy;

  colour_rom_arbiter_if #(.IDX_W(3), .DATA_W(24)) bus ();

  colour_rom_arbiter #(.ROM_LATENCY(2), .IDX_W(3), .DATA_W(24)) dut (
    .clk  (clk),
    .rst  (rst),
    .hold (hold),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // ROM model: address sampled at edge 1, data visible after edge 2.
  logic [23:0] mem [0:7];
  logic [23:0] rom_s1 = 24'h000000;
  logic [23:0] rom_s2 = 24'h000000;
  always @(posedge clk) begin
    if (bus.rom_en) rom_s1 <= mem[bus.rom_addr];
    rom_s2 <= rom_s1;
  end
  assign bus.rom_data = rom_s2;

  typedef struct {
    logic        rst;
    logic        hold;
    logic        req0;
    logic [2:0]  idx0;
    logic        req1;
    logic [2:0]  idx1;
    logic        gnt0;
    logic        gnt1;
    logic        en;
    logic [2:0]  addr;
    logic [23:0] l0;
    logic [23:0] l1;
    logic        v0;
    logic        v1;
    logic        busy;
  } row_t;

  row_t tbl[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic row_t mk(logic r, logic h, logic q0, logic [2:0] i0,
                              logic q1, logic [2:0] i1, logic g0, logic g1,
                              logic en, logic [2:0] a, logic [23:0] l0,
                              logic [23:0] l1, logic v0, logic v1, logic b);
    row_t x;
    x.rst = r; x.hold = h; x.req0 = q0; x.idx0 = i0; x.req1 = q1; x.idx1 = i1;
    x.gnt0 = g0; x.gnt1 = g1; x.en = en; x.addr = a; x.l0 = l0; x.l1 = l1;
    x.v0 = v0; x.v1 = v1; x.busy = b;
    return x;
  endfunction

  task automatic chk(string nm, logic [23:0] act, logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge, drive inputs, then wait to mid-cycle.
  task automatic drive(logic r, logic h, logic q0, logic [2:0] i0, logic q1, logic [2:0] i1);
    @(posedge clk);
    #1;
    rst = r; hold = h;
    bus.req0 = q0; bus.idx0 = i0; bus.req1 = q1; bus.idx1 = i1;
    #4;
  endtask

  initial begin
    mem[0] = 24'h000000; mem[1] = 24'h0000FF; mem[2] = 24'h00FF00; mem[3] = 24'h00FFFF;
    mem[4] = 24'hFF0000; mem[5] = 24'hFF00FF; mem[6] = 24'hFFFF00; mem[7] = 24'hFFFFFF;

    rst = 1'b1; hold = 1'b0;
    bus.req0 = 1'b0; bus.idx0 = 3'd0; bus.req1 = 1'b0; bus.idx1 = 3'd0;
    #3;
    chk("rst_light0", bus.light0, 24'h000000);
    chk("rst_busy", {23'd0, busy}, 24'd0);

    // Release reset, then ten idle cycles with no activity.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #5;
      chk($sformatf("idle%0d_light0", i), bus.light0, 24'h000000);
      chk($sformatf("idle%0d_light1", i), bus.light1, 24'h000000);
      chk($sformatf("idle%0d_valid", i), {22'd0, bus.valid1, bus.valid0}, 24'd0);
      chk($sformatf("idle%0d_busy", i), {23'd0, busy}, 24'd0);
    end

    //                rst  hold r0 i0    r1 i1    g0 g1 en addr  light0        light1        v0 v1 busy
    // single read of index 1 on channel 0
    tbl.push_back(mk(1'b0,1'b0,1'b1,3'd1,1'b0,3'd0,1'b1,1'b0,1'b1,3'd1,24'h000000,24'h000000,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h000000,24'h000000,1'b0,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h000000,24'h000000,1'b0,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h0000FF,24'h000000,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h0000FF,24'h000000,1'b0,1'b0,1'b0));
    // contention: requests present during reset and held after release
    tbl.push_back(mk(1'b1,1'b0,1'b1,3'd2,1'b1,3'd4,1'b0,1'b0,1'b0,3'd0,24'h000000,24'h000000,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,3'd2,1'b1,3'd4,1'b1,1'b0,1'b1,3'd2,24'h000000,24'h000000,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,3'd2,1'b1,3'd4,1'b0,1'b1,1'b1,3'd4,24'h000000,24'h000000,1'b0,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,3'd2,1'b1,3'd4,1'b1,1'b0,1'b1,3'd2,24'h000000,24'h000000,1'b0,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,3'd2,1'b1,3'd4,1'b0,1'b1,1'b1,3'd4,24'h00FF00,24'h000000,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h00FF00,24'hFF0000,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h00FF00,24'hFF0000,1'b1,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h00FF00,24'hFF0000,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h00FF00,24'hFF0000,1'b0,1'b0,1'b0));
    // back-to-back grants to channel 1 (sole requester although it was granted last)
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b1,3'd5,1'b0,1'b1,1'b1,3'd5,24'h00FF00,24'hFF0000,1'b0,1'b0,1'b0));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b1,3'd6,1'b0,1'b1,1'b1,3'd6,24'h00FF00,24'hFF0000,1'b0,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b1,3'd7,1'b0,1'b1,1'b1,3'd7,24'h00FF00,24'hFF0000,1'b0,1'b0,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h00FF00,24'hFF00FF,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h00FF00,24'hFFFF00,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h00FF00,24'hFFFFFF,1'b0,1'b1,1'b1));
    tbl.push_back(mk(1'b0,1'b0,1'b0,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0,24'h00FF00,24'hFFFFFF,1'b0,1'b0,1'b0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].hold, tbl[i].req0, tbl[i].idx0, tbl[i].req1, tbl[i].idx1);
      chk($sformatf("row%0d_gnt", i), {22'd0, bus.gnt1, bus.gnt0}, {22'd0, tbl[i].gnt1, tbl[i].gnt0});
      chk($sformatf("row%0d_rom_en", i), {23'd0, bus.rom_en}, {23'd0, tbl[i].en});
      chk($sformatf("row%0d_rom_addr", i), {21'd0, bus.rom_addr}, {21'd0, tbl[i].addr});
      chk($sformatf("row%0d_light0", i), bus.light0, tbl[i].l0);
      chk($sformatf("row%0d_light1", i), bus.light1, tbl[i].l1);
      chk($sformatf("row%0d_valid", i), {22'd0, bus.valid1, bus.valid0}, {22'd0, tbl[i].v1, tbl[i].v0});
      chk($sformatf("row%0d_busy", i), {23'd0, busy}, {23'd0, tbl[i].busy});
    end

    // Hold: read of index 6 in flight, new request for index 3 held off.
    drive(1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'd0);
    chk("hold_pre_gnt0", {23'd0, bus.gnt0}, 24'd1);
    chk("hold_pre_addr", {21'd0, bus.rom_addr}, 24'd6);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 3'd0);
      chk($sformatf("hold%0d_gnt0", i), {23'd0, bus.gnt0}, 24'd0);
      chk($sformatf("hold%0d_rom_en", i), {23'd0, bus.rom_en}, 24'd0);
      if (i == 2) begin
        chk("hold_inflight_light0", bus.light0, 24'hFFFF00);
        chk("hold_inflight_valid0", {23'd0, bus.valid0}, 24'd1);
      end
    end
    drive(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    chk("hold_release_gnt0", {23'd0, bus.gnt0}, 24'd1);
    chk("hold_release_addr", {21'd0, bus.rom_addr}, 24'd3);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("hold_after_light0", bus.light0, 24'h00FFFF);
    chk("hold_after_valid0", {23'd0, bus.valid0}, 24'd1);
    drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);

    // Reset one cycle after a grant: the read must vanish.
    drive(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
    chk("midrst_gnt0", {23'd0, bus.gnt0}, 24'd1);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("midrst_light0", bus.light0, 24'h000000);
    chk("midrst_light1", bus.light1, 24'h000000);
    chk("midrst_busy", {23'd0, busy}, 24'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
      chk($sformatf("postrst%0d_light0", i), bus.light0, 24'h000000);
      chk($sformatf("postrst%0d_valid0", i), {23'd0, bus.valid0}, 24'd0);
      chk($sformatf("postrst%0d_busy", i), {23'd0, busy}, 24'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
